// File: rtl/any1_pkg.sv
// any1 shared types: ROB geometry and the reorder-buffer entry layout seen by
// the issue path. Slot IDs are 6 bits, so ROB_ENTRIES is at most 64.
package any1_pkg;
   localparam int ROB_ENTRIES = 64;

   typedef struct packed {
      logic        v;     // entry holds a live instruction
      logic        out;   // entry has been issued to execute
      logic        done;  // execution finished
      logic [7:0]  op;    // decoded opcode
      logic [31:0] pc;    // instruction address
   } sReorderEntry;
endpackage

// File: rtl/any1_issue_buffer.sv
// any1_issue_buffer
//   Captures scheduler selections, snapshots the chosen ROB entry, pulses the
//   ROB to mark it "out", and queues issued entries in an in-order FIFO that
//   feeds execute over valid/ready. Heads whose ROB slot has been invalidated
//   are discarded without waiting for execute.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   rob             live ROB contents
//   selection       [6]=no selection, [5:0]=ROB slot
//   flush           synchronous pipeline flush
//   set_out/_rid    one-cycle pulse telling the ROB to set the out flag
//   ex_valid/ready  handshake to execute; ex_rid/ex_entry describe the head
//   full            registered count==DEPTH
//   sel_drop        pulse: a valid selection was rejected
//
// Optional build macro ANY1_ISSUE_STATS_EN adds saturating 32-bit counters
// stat_issued, stat_dropped and stat_stale (cleared only by rst_n).
module any1_issue_buffer #(
   parameter int DEPTH = 4,
   parameter int ROBE  = any1_pkg::ROB_ENTRIES
) (
   input  logic                                rst_n,
   input  logic                                clk,
   input  any1_pkg::sReorderEntry [ROBE-1:0]   rob,
   input  logic [6:0]                          selection,
   input  logic                                flush,
   output logic                                set_out,
   output logic [5:0]                          set_out_rid,
   output logic                                ex_valid,
   input  logic                                ex_ready,
   output logic [5:0]                          ex_rid,
   output any1_pkg::sReorderEntry              ex_entry,
   output logic                                full,
   output logic                                sel_drop
`ifdef ANY1_ISSUE_STATS_EN
   ,
   output logic [31:0]                         stat_issued,
   output logic [31:0]                         stat_dropped,
   output logic [31:0]                         stat_stale
`endif
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DEPTH-1:0]                    ent_vld;
   logic [DEPTH-1:0][5:0]               ent_rid;
   any1_pkg::sReorderEntry [DEPTH-1:0]  ent_data;
   logic [AW-1:0]                       rd_ptr, wr_ptr;
   logic [AW:0]                         count, count_nxt;

   logic [5:0] sel_rid;
   logic       sel_req, head_vld, head_live, dup, push, pop, stale_pop;

   assign sel_rid  = selection[5:0];
   assign sel_req  = ~selection[6];

   // Head is read straight from storage; ex_* only change at a pop or push
   // edge, so they stay stable while execute stalls.
   assign head_vld  = ent_vld[rd_ptr];
   assign ex_rid    = ent_rid[rd_ptr];
   assign ex_entry  = ent_data[rd_ptr];
   assign head_live = rob[ex_rid].v;
   assign ex_valid  = head_vld & head_live;
   assign stale_pop = head_vld & ~head_live;
   assign pop       = (ex_valid & ex_ready) | stale_pop;

   // A slot already waiting in the queue must not be issued twice.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_vld[i] && ent_rid[i] == sel_rid) dup = 1'b1;
   end

   // A pop in the same cycle frees a slot, so a full queue can still accept.
   assign push = sel_req & ~flush & ~dup & ((count != CNT_FULL) | pop);

   always_comb begin
      count_nxt = count;
      if (flush)              count_nxt = '0;
      else if (push && !pop)  count_nxt = count + CNT_ONE;
      else if (pop && !push)  count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld     <= '0;
         ent_rid     <= '0;
         ent_data    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         set_out     <= 1'b0;
         set_out_rid <= '0;
         sel_drop    <= 1'b0;
      end else begin
         set_out  <= push;
         sel_drop <= sel_req & ~push;
         if (push) set_out_rid <= sel_rid;
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         if (flush) begin
            ent_vld <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
         end else begin
            if (pop) begin
               ent_vld[rd_ptr] <= 1'b0;
               rd_ptr          <= rd_ptr + PTR_ONE;
            end
            // Ordered after the pop so a full push+pop on the same slot
            // leaves it valid with the new contents.
            if (push) begin
               ent_vld[wr_ptr]  <= 1'b1;
               ent_rid[wr_ptr]  <= sel_rid;
               ent_data[wr_ptr] <= rob[sel_rid];
               wr_ptr           <= wr_ptr + PTR_ONE;
            end
         end
      end
   end

`ifdef ANY1_ISSUE_STATS_EN
   // Counted at the same edge that registers the matching pulse.
   logic drop_ev, stale_ev;
   assign drop_ev  = sel_req & ~push;
   assign stale_ev = stale_pop & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued  <= '0;
         stat_dropped <= '0;
         stat_stale   <= '0;
      end else begin
         if (push && stat_issued != 32'hFFFF_FFFF)      stat_issued  <= stat_issued + 32'd1;
         if (drop_ev && stat_dropped != 32'hFFFF_FFFF)  stat_dropped <= stat_dropped + 32'd1;
         if (stale_ev && stat_stale != 32'hFFFF_FFFF)   stat_stale   <= stat_stale + 32'd1;
      end
   end
`endif
endmodule

// File: doc/any1_issue_buffer.md
Name: any1_issue_buffer

Overview:
- Sits directly downstream of the any1 instruction scheduler, between scheduler selection and the execute unit.
- Captures each 7-bit selection, snapshots the selected ROB entry and tells the ROB to set that entry's "out" flag.
- Queues the issued entries in a small in-order FIFO and hands them to execute over a valid/ready handshake.
- Drops issues that are stale (flushed or invalidated) so execute never sees a dead ROB slot.

Parameters:
- DEPTH, 4, FIFO entries; legal values 2, 4 or 8 (power of two).
- ROBE, ROB_ENTRIES from any1_pkg, number of ROB slots; slot IDs are 6 bits.

Ports:
- rst_n  input  1  asynchronous active-low reset
- clk  input  1  clock
- rob  input  sReorderEntry[ROBE-1:0]  live ROB contents
- selection  input  7  scheduler output; bit6=1 means no selection, [5:0]=ROB slot
- flush  input  1  pipeline flush (branch mispredict or exception), synchronous
- set_out  output  1  one-cycle pulse: ROB must set out flag of set_out_rid
- set_out_rid  output  6  slot whose out flag is set
- ex_valid  output  1  head entry is presented to execute
- ex_ready  input  1  execute accepts head this cycle
- ex_rid  output  6  ROB slot of head
- ex_entry  output  sReorderEntry  snapshot of rob[ex_rid] taken at accept time
- full  output  1  count==DEPTH
- sel_drop  output  1  pulse: valid selection rejected (full, duplicate or flush)

Behaviour:
- Reset (rst_n low, async): count=0, rd/wr pointers=0, all entry valid bits=0, set_out=0, set_out_rid=0, ex_valid=0, ex_rid=0, ex_entry=0, sel_drop=0, full=0.
- Accept condition (cycle N): selection[6]==0, !flush, count<DEPTH (or a pop happens in the same cycle), and selection[5:0] does not match the rid of any valid FIFO entry.
- On accept: write {rid, rob[rid]} at wr_ptr and advance wr_ptr mod DEPTH.
  - set_out=1 and set_out_rid=rid registered in cycle N+1; exactly one pulse per accepted issue.
- Valid selection that is not accepted: sel_drop=1 at N+1, no set_out.
  - The entry's out flag stays clear, so the scheduler reselects it after its 4-deep already-chosen window expires.
- Pop: ex_valid && ex_ready at a rising edge; advance rd_ptr.
- Simultaneous push and pop while full: allowed; count is unchanged.
- Latency: a selection accepted into an empty FIFO gives ex_valid=1 with that rid at N+1. No combinational path from selection to ex_*.
- ex_valid = head valid && rob[head rid].v; evaluated combinationally against live rob.
  - Stale head (rob v cleared after issue) is popped silently without waiting for ex_ready; ex_valid=0 that cycle.
- ex_entry and ex_rid are held stable while ex_valid && !ex_ready.
- flush: at the next edge clear all valid bits, count=0, pointers=0, ex_valid=0.
  - A selection presented in the flush cycle is dropped (sel_drop=1), and no set_out is raised.
  - flush dominates a simultaneous push or pop.
- full is registered from the next count.
- Pointer wrap: rd_ptr and wr_ptr are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.
- Empty FIFO with ex_ready high: no effect.
- Reset asserted mid-operation: all state clears immediately. An in-flight set_out pulse is lost, and the ROB is reset by the same rst_n.

Optional Feature:
- ANY1_ISSUE_STATS_EN: when defined, adds outputs stat_issued[31:0], stat_dropped[31:0] and stat_stale[31:0].
  - Counters increment on set_out, sel_drop and stale-pop respectively.
  - They saturate at 32'hFFFFFFFF and clear only on rst_n (flush does not clear them).
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset, then selection=7'h05 at cycle 1, ex_ready=1 -> set_out=1, set_out_rid=5, ex_valid=1 and ex_rid=5 at cycle 2; popped at cycle 2's edge, ex_valid=0 at cycle 3.
- ex_ready=0; selections 1,2,3,4,7 on consecutive cycles (DEPTH=4) -> full=1 after the fourth, sel_drop=1 for rid 7, no set_out for 7; raise ex_ready -> rids 1,2,3,4 appear in order, one per cycle.
- ex_ready=0; selection=9 twice on consecutive cycles -> second gives sel_drop=1, and only one set_out with rid 9.
- Queue holding rids 3,4; clear rob[3].v -> rid 3 popped with ex_valid never high for it; ex_rid=4 next cycle.
- Queue holding 2 entries; flush together with selection=6 -> next cycle count=0, ex_valid=0, sel_drop=1, set_out=0.
- Drop rst_n asynchronously between clock edges while the FIFO is full -> all outputs 0 immediately; after release, selection=1 issues normally (with ANY1_ISSUE_STATS_EN: stat_issued=1).
